// File: rtl/spike_class_decoder_pkg.sv
// spike_class_decoder_pkg
//   Shared constants for the spike class decoder: class indices, FSM state
//   encoding, default counter/window widths and the registered result type.
package spike_class_decoder_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 24;

  // Output neuron / character class indices
  localparam logic [1:0] CLASS_A = 2'd0;
  localparam logic [1:0] CLASS_J = 2'd1;
  localparam logic [1:0] CLASS_N = 2'd2;
  localparam logic [1:0] CLASS_X = 2'd3;

  // FSM state encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COUNT   = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // Registered classification result, held from DONE until the next result
  typedef struct packed {
    logic [1:0] cls;
    logic       tie;
  } result_t;

endpackage

// File: rtl/spike_class_decoder_if.sv
// spike_class_decoder_if
//   Control/result bus of the spike class decoder.
//   start        : one-cycle measurement request (controller -> decoder)
//   window_len   : measurement length in clk cycles, latched on start
//   busy         : decoder is counting or comparing
//   result_valid : one-cycle pulse when class_out/tie are updated
//   class_out    : winning class index
//   tie          : two or more classes share the maximum count
//   spike_counts : live per-class counts, class 0 in the LSBs
//                  (only when SPIKE_COUNT_OUT_EN is defined)
// Modports: master = controller side, slave = decoder side.
interface spike_class_decoder_if #(
  parameter int NUM_CLASSES = 4,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 24
);
  logic                         start;
  logic [WIN_W-1:0]             window_len;
  logic                         busy;
  logic                         result_valid;
  logic [$clog2(NUM_CLASSES)-1:0] class_out;
  logic                         tie;
`ifdef SPIKE_COUNT_OUT_EN
  logic [NUM_CLASSES*CNT_W-1:0] spike_counts;

  modport master (output start, window_len,
                  input  busy, result_valid, class_out, tie, spike_counts);
  modport slave  (input  start, window_len,
                  output busy, result_valid, class_out, tie, spike_counts);
`else
  modport master (output start, window_len,
                  input  busy, result_valid, class_out, tie);
  modport slave  (input  start, window_len,
                  output busy, result_valid, class_out, tie);
`endif

endinterface

// File: rtl/spike_edge_sync.sv
// spike_edge_sync
//   Synchronizes one asynchronous spike line into the clk domain and flags
//   its rising edges. The previous-value register runs every cycle, so a
//   line that is already high produces no edge until it falls and rises.
//   clk  : system clock
//   rst  : synchronous, active-high reset (clears all stages)
//   din  : asynchronous spike line
//   rise : one-cycle pulse on a synchronized rising edge
module spike_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("spike_edge_sync: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/spike_class_decoder.sv
// spike_class_decoder
//   Counts rising edges on each output-neuron spike line over a programmable
//   window, then finds the winning class by a sequential argmax (one class
//   per cycle, lowest index wins ties) and reports it with a one-cycle pulse.
//   clk      : system clock
//   rst      : synchronous, active-high reset
//   spike_in : asynchronous spike lines, one per class
//   ctl      : control/result bus (slave side), see spike_class_decoder_if
// Optional: define SPIKE_COUNT_OUT_EN to drive ctl.spike_counts with the
// live counters.
module spike_class_decoder
  import spike_class_decoder_pkg::*;
#(
  parameter int NUM_CLASSES = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLASSES-1:0] spike_in,
  spike_class_decoder_if.slave   ctl
);

  // Class encoding is 2 bits wide, so the last compared class is CLASS_X.
  localparam logic [1:0] LAST_IDX = CLASS_X;

  logic [1:0]                        state;
  logic [WIN_W-1:0]                  timer;
  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt;
  logic [NUM_CLASSES-1:0]            rise;
  logic [1:0]                        cmp_idx;
  logic [CNT_W-1:0]                  max_val;
  logic [1:0]                        max_idx;
  logic                              tie_run;
  result_t                           res_q;
  logic                              valid_q;

  logic                              start_ok;
  logic [WIN_W-1:0]                  win_m1;
  logic [CNT_W-1:0]                  cur_cnt;
  logic [CNT_W-1:0]                  nxt_max;
  logic [1:0]                        nxt_idx;
  logic                              nxt_tie;

  // Per-line synchronizer + edge detector
  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_lane
    spike_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (spike_in[g]),
      .rise (rise[g])
    );
  end

  assign start_ok = ctl.start && (state == IDLE || state == DONE);

  // Timer counts down to 0 inclusive, so load N-1; a zero length acts as 1.
  assign win_m1 = (ctl.window_len == '0) ? '0 : ctl.window_len - WIN_W'(1);

  // Sequential argmax step for the class at cmp_idx
  assign cur_cnt = cnt[cmp_idx];
  always_comb begin
    nxt_max = max_val;
    nxt_idx = max_idx;
    nxt_tie = tie_run;
    if (cmp_idx == CLASS_A) begin
      nxt_max = cur_cnt;
      nxt_idx = CLASS_A;
      nxt_tie = 1'b0;
    end else if (cur_cnt > max_val) begin
      nxt_max = cur_cnt;
      nxt_idx = cmp_idx;
      nxt_tie = 1'b0;
    end else if (cur_cnt == max_val) begin
      nxt_tie = 1'b1;
    end
  end

  // Saturating per-class counters; the clear on start wins over an edge
  // arriving in the same cycle.
  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst || start_ok)
        cnt[g] <= '0;
      else if (state == COUNT && rise[g] && cnt[g] != {CNT_W{1'b1}})
        cnt[g] <= cnt[g] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      cmp_idx <= '0;
      max_val <= '0;
      max_idx <= '0;
      tie_run <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start_ok) begin
        state <= COUNT;
        timer <= win_m1;
      end else begin
        case (state)
          COUNT: begin
            if (timer == '0) begin
              state   <= COMPARE;
              cmp_idx <= CLASS_A;
            end else begin
              timer <= timer - WIN_W'(1);
            end
          end
          COMPARE: begin
            max_val <= nxt_max;
            max_idx <= nxt_idx;
            tie_run <= nxt_tie;
            cmp_idx <= cmp_idx + 2'd1;
            if (cmp_idx == LAST_IDX) begin
              state     <= DONE;
              res_q.cls <= nxt_idx;
              res_q.tie <= nxt_tie;
              valid_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ctl.busy         = (state == COUNT) || (state == COMPARE);
  assign ctl.result_valid = valid_q;
  assign ctl.class_out    = res_q.cls;
  assign ctl.tie          = res_q.tie;

`ifdef SPIKE_COUNT_OUT_EN
  assign ctl.spike_counts = cnt;
`else
  // Counters are only observable through class_out and tie.
`endif

endmodule

// File: tb/tb_spike_class_decoder.sv
// tb_spike_class_decoder
//   Directed bench for spike_class_decoder: classification, ties,
//   saturation (CNT_W=4), zero window, pre-high line, start during COUNT and
//   reset mid-COUNT with restart.
module tb_spike_class_decoder;

  localparam int NC = 4;
  localparam int CW = 4;
  localparam int WW = 24;

  logic          clk;
  logic          rst;
  logic [NC-1:0] spike_in;
  logic [NC-1:0] hold;
  int            checks;
  int            errs;
  int            exp_prev_cls;
  int            lat;
  int            rv_seen;

  spike_class_decoder_if #(.NUM_CLASSES(NC), .CNT_W(CW), .WIN_W(WW)) bus ();

  spike_class_decoder #(
    .NUM_CLASSES (NC),
    .CNT_W       (CW),
    .WIN_W       (WW),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .spike_in (spike_in),
    .ctl      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulses of 2 cycles high / 2 low, n[c] per class, ORed with hold.
  task automatic drive_pulses(input int n0, input int n1, input int n2, input int n3);
    int n[NC];
    int mx;
    n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
    mx = 0;
    for (int c = 0; c < NC; c++) if (n[c] > mx) mx = n[c];
    @(negedge clk);
    for (int t = 0; t < mx * 4; t++) begin
      @(negedge clk);
      for (int c = 0; c < NC; c++)
        spike_in[c] = hold[c] | ((t % 4 < 2) && (t / 4 < n[c]));
    end
    @(negedge clk);
    spike_in = hold;
  endtask

  // Start a measurement, optionally pulse start again at cycle mid, and
  // return the cycle (relative to the start cycle) where result_valid is seen.
  task automatic run_meas(input int len, input int mid, output int l);
    @(negedge clk);
    bus.window_len = len;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    l = 1;
    chk("busy_in_count", bus.busy, 1);
    chk("class_held", bus.class_out, exp_prev_cls);
    while (!bus.result_valid && l < 1000) begin
      @(negedge clk);
      l++;
      bus.start = (l == mid);
      if (l == mid) bus.window_len = 5;
    end
    bus.start = 1'b0;
    chk("result_valid_seen", bus.result_valid, 1);
  endtask

  task automatic check_result(input string tag, input int l, input int exp_lat,
                              input int cls, input int t);
    chk({tag, "_latency"}, l, exp_lat);
    chk({tag, "_class"}, bus.class_out, cls);
    chk({tag, "_tie"}, bus.tie, t);
    @(negedge clk);
    chk({tag, "_valid_pulse"}, bus.result_valid, 0);
    chk({tag, "_busy_done"}, bus.busy, 0);
    exp_prev_cls = cls;
  endtask

  initial begin
    checks = 0; errs = 0; exp_prev_cls = 0;
    rst = 1'b1; spike_in = '0; hold = '0;
    bus.start = 1'b0; bus.window_len = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_class", bus.class_out, 0);
    chk("rst_tie", bus.tie, 0);
`ifdef SPIKE_COUNT_OUT_EN
    chk("rst_counts", bus.spike_counts, 0);
`endif

    // Basic classification 3/7/2/5
    fork
      run_meas(100, 0, lat);
      drive_pulses(3, 7, 2, 5);
    join
`ifdef SPIKE_COUNT_OUT_EN
    chk("basic_cnt0", bus.spike_counts[0*CW +: CW], 3);
    chk("basic_cnt1", bus.spike_counts[1*CW +: CW], 7);
    chk("basic_cnt2", bus.spike_counts[2*CW +: CW], 2);
    chk("basic_cnt3", bus.spike_counts[3*CW +: CW], 5);
`endif
    check_result("basic", lat, 105, 1, 0);

    // Tie between classes 2 and 3
    fork
      run_meas(50, 0, lat);
      drive_pulses(0, 0, 4, 4);
    join
    check_result("tie", lat, 55, 2, 1);

    // Saturation at 15 with CNT_W=4
    fork
      run_meas(200, 0, lat);
      drive_pulses(20, 15, 0, 0);
    join
`ifdef SPIKE_COUNT_OUT_EN
    chk("sat_cnt0", bus.spike_counts[0*CW +: CW], 15);
    chk("sat_cnt1", bus.spike_counts[1*CW +: CW], 15);
`endif
    check_result("sat", lat, 205, 0, 1);

    // Zero window, silence
    run_meas(0, 0, lat);
    check_result("zero", lat, 6, 0, 1);

    // Line 3 high before and through the window
    hold = 4'b1000;
    spike_in = hold;
    repeat (6) @(negedge clk);
    fork
      run_meas(50, 0, lat);
      drive_pulses(0, 1, 0, 0);
    join
`ifdef SPIKE_COUNT_OUT_EN
    chk("prehigh_cnt3", bus.spike_counts[3*CW +: CW], 0);
`endif
    check_result("prehigh", lat, 55, 1, 0);
    hold = '0;
    spike_in = '0;
    repeat (6) @(negedge clk);

    // start during COUNT must not change the window
    fork
      run_meas(40, 10, lat);
      drive_pulses(0, 0, 0, 2);
    join
    check_result("midstart", lat, 45, 3, 0);

    // Reset mid-COUNT, then restart
    @(negedge clk);
    bus.window_len = 100;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_class", bus.class_out, 0);
    chk("abort_tie", bus.tie, 0);
    rv_seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (bus.result_valid) rv_seen++;
    end
    chk("abort_no_valid", rv_seen, 0);
    exp_prev_cls = 0;
    fork
      run_meas(20, 0, lat);
      drive_pulses(0, 0, 2, 0);
    join
    check_result("restart", lat, 25, 2, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
